// File: rtl/and3_in_debounce_if.sv
// Signal bundle between the raw-level sources and the AND3 input debouncer.
// The master drives the raw levels; the slave (debouncer) returns clean levels and status.
interface and3_in_debounce_if;
    logic a_raw;
    logic b_raw;
    logic c_raw;
    logic A;
    logic B;
    logic C;
    logic chg;
    logic all_stable;

    modport master (
        output a_raw, b_raw, c_raw,
        input  A, B, C, chg, all_stable
    );

    modport slave (
        input  a_raw, b_raw, c_raw,
        output A, B, C, chg, all_stable
    );
endinterface

// File: rtl/and3_in_debounce.sv
// Three independent synchronise-and-debounce channels feeding an AND3 cell.
// An output follows its synchronised input only after STABLE_CYCLES consecutive differing cycles.
module and3_in_debounce #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    and3_in_debounce_if.slave bus
);
    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("and3_in_debounce: STABLE_CYCLES must be >= 1");
        end
        if ((64'd1 << CNT_W) < 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
            $error("and3_in_debounce: CNT_W too narrow for STABLE_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    // Bit 0 = channel A, bit 1 = channel B, bit 2 = channel C.
    logic [2:0]       raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       out;
    logic [2:0]       flip;
    logic [CNT_W-1:0] cnt [3];
    logic             chg_q;

    assign raw = {bus.c_raw, bus.b_raw, bus.a_raw};

    // A channel flips when its difference has persisted for the full threshold.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 3; i++) begin
            flip[i] = (s2[i] != out[i]) && (cnt[i] == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            out   <= '0;
            chg_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            chg_q <= |flip;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == out[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    out[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.A          = out[0];
    assign bus.B          = out[1];
    assign bus.C          = out[2];
    assign bus.chg        = chg_q;
    assign bus.all_stable = (s2 == out);
endmodule

// File: tb/tb_and3_in_debounce.sv
// Directed table-driven bench for and3_in_debounce (default and STABLE_CYCLES=1 builds).
// Each row holds the inputs applied before an edge and the outputs expected just after it.
module tb_and3_in_debounce;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    and3_in_debounce_if bus0 ();
    and3_in_debounce_if bus1 ();

    and3_in_debounce #(.STABLE_CYCLES(8), .CNT_W(4)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.slave)
    );

    and3_in_debounce #(.STABLE_CYCLES(1), .CNT_W(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    typedef struct {
        logic       rst;
        logic [2:0] raw;   // {c,b,a}
        logic [2:0] out;   // {C,B,A}
        logic       chg;
        logic       st;
    } vec_t;

    vec_t  vecs  [$];
    string names [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic add(input string nm, input logic r, input logic [2:0] raw,
                       input logic [2:0] out, input logic chg, input logic st, input int n);
        vec_t v;
        v.rst = r; v.raw = raw; v.out = out; v.chg = chg; v.st = st;
        for (int k = 0; k < n; k++) begin
            vecs.push_back(v);
            names.push_back(nm);
        end
    endtask

    task automatic check(input string nm, input int idx, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b expected %b", nm, idx, got, exp);
        end
    endtask

    // A full rise of raw pattern p from a settled state q: 10th edge updates outputs.
    task automatic add_settle(input string nm, input logic [2:0] p, input logic [2:0] q);
        add(nm, 1'b0, p, q, 1'b0, 1'b1, 1);
        add(nm, 1'b0, p, q, 1'b0, 1'b0, 8);
        add(nm, 1'b0, p, p, 1'b1, 1'b1, 1);
        add(nm, 1'b0, p, p, 1'b0, 1'b1, 2);
    endtask

    logic hist [0:15];

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.a_raw = 1'b0; bus0.b_raw = 1'b0; bus0.c_raw = 1'b0;
        bus1.a_raw = 1'b0; bus1.b_raw = 1'b0; bus1.c_raw = 1'b0;

        // Reset with all raw high, then release and let everything rise, then fall.
        add("reset",     1'b1, 3'b111, 3'b000, 1'b0, 1'b1, 3);
        add_settle("rise_all", 3'b111, 3'b000);
        add_settle("fall_all", 3'b000, 3'b111);

        // 5-cycle glitch on a_raw never reaches A.
        add("glitch",    1'b0, 3'b001, 3'b000, 1'b0, 1'b1, 1);
        add("glitch",    1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 4);
        add("glitch",    1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1);
        add("glitch",    1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 4);

        // a_raw high exactly 8 cycles: A rises on edge 10, falls 8 edges later.
        add("thresh",    1'b0, 3'b001, 3'b000, 1'b0, 1'b1, 1);
        add("thresh",    1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 7);
        add("thresh",    1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1);
        add("thresh",    1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 1);
        add("thresh",    1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 7);
        add("thresh",    1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1);
        add("thresh",    1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 2);

        // a and c together: one chg pulse, B untouched.
        add_settle("simul_rise", 3'b101, 3'b000);
        add_settle("simul_fall", 3'b000, 3'b101);

        // b glitches while a counts: a's count is unaffected.
        add("indep",     1'b0, 3'b011, 3'b000, 1'b0, 1'b1, 1);
        add("indep",     1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 2);
        add("indep",     1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 6);
        add("indep",     1'b0, 3'b001, 3'b001, 1'b1, 1'b1, 1);
        add("indep",     1'b0, 3'b001, 3'b001, 1'b0, 1'b1, 2);
        add_settle("indep_fall", 3'b000, 3'b001);

        // b counting, reset lands on the 6th counting edge, then full restart.
        add("rst_mid",   1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 1);
        add("rst_mid",   1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 6);
        add("rst_mid",   1'b1, 3'b010, 3'b000, 1'b0, 1'b1, 1);
        add_settle("rst_mid_rise", 3'b010, 3'b000);
        add_settle("rst_mid_fall", 3'b000, 3'b010);

        for (int i = 0; i < vecs.size(); i++) begin
            rst0       = vecs[i].rst;
            bus0.a_raw = vecs[i].raw[0];
            bus0.b_raw = vecs[i].raw[1];
            bus0.c_raw = vecs[i].raw[2];
            @(posedge clk);
            #1;
            check({names[i], "_out"},    i, {bus0.C, bus0.B, bus0.A}, vecs[i].out);
            check({names[i], "_chg"},    i, {2'b00, bus0.chg},        {2'b00, vecs[i].chg});
            check({names[i], "_stable"}, i, {2'b00, bus0.all_stable}, {2'b00, vecs[i].st});
        end

        // STABLE_CYCLES=1: C equals raw from two edges earlier, chg on each toggle.
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        check("s1_reset", 0, {bus1.C, bus1.chg, bus1.all_stable}, 3'b001);
        rst1 = 1'b0;
        for (int n = 0; n < 16; n++) hist[n] = 1'b0;
        for (int n = 2; n < 16; n++) begin
            hist[n] = (((n - 2) / 3) % 2) == 0;
            bus1.c_raw = hist[n];
            @(posedge clk);
            #1;
            check("s1_C",      n, {2'b00, bus1.C},          {2'b00, hist[n-2]});
            check("s1_chg",    n, {2'b00, bus1.chg},        {2'b00, hist[n-2] != hist[n-3]});
            check("s1_stable", n, {2'b00, bus1.all_stable}, {2'b00, hist[n-1] == hist[n-2]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/and3_in_debounce.md
Name: and3_in_debounce

Overview:
Input-conditioning stage that sits directly upstream of the 3-input AND cell. It takes three asynchronous raw level inputs, synchronises each one and debounces it, and drives clean, glitch-free levels A/B/C into the AND3 instance. It also flags output changes and overall stability, for monitoring by the surrounding logic.

Parameters:
STABLE_CYCLES, 8, number of consecutive cycles a synchronised input must differ from its output before the output follows; legal range >= 1
CNT_W, 4, debounce counter width; must satisfy 2**CNT_W >= STABLE_CYCLES (elaboration-time check required)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous reset, active-high
a_raw  input  1  raw asynchronous level, channel A
b_raw  input  1  raw asynchronous level, channel B
c_raw  input  1  raw asynchronous level, channel C
A  output  1  debounced level A; feeds AND3 .A
B  output  1  debounced level B; feeds AND3 .B
C  output  1  debounced level C; feeds AND3 .C
chg  output  1  one-cycle pulse when any of A/B/C toggled on this edge
all_stable  output  1  high when every synchronised input equals its debounced output

Behaviour:
- Three identical, independent channels. Per channel state:
  - s1, s2: two-flop synchroniser
  - out: debounced level, driven on A/B/C
  - cnt: CNT_W bits
- Reset (rst=1 at a rising edge): s1, s2, out, cnt <= 0; chg <= 0.
- Reset values: A=B=C=0, chg=0, all_stable=1.
- Reset is synchronous only; nothing changes between clock edges.
- Each edge: s1 <= x_raw; s2 <= s1.
- Each edge, per channel:
  - If s2 == out: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: out <= s2; cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency:
  - Raw level first sampled at edge E0 and held. out changes at edge E0+STABLE_CYCLES+1.
  - Default (STABLE_CYCLES=8): the 10th rising edge, counting E0 as the 1st.
  - STABLE_CYCLES=1: out changes at E0+2.
- Glitch rejection: if s2 returns to out before the threshold, cnt clears. The next change then needs the full STABLE_CYCLES again; no partial credit is kept.
- A change shorter than STABLE_CYCLES cycles at s2 never reaches the output.
- cnt never exceeds STABLE_CYCLES-1; no wrap-around.
- chg: registered. chg <= 1 on the edge where any out toggles, otherwise 0.
  - Simultaneous toggles on several channels give a single one-cycle pulse.
  - chg is asserted in the same cycle the new A/B/C values appear.
- all_stable: combinational from registers.
  - Formula: (s2_a==A) & (s2_b==B) & (s2_c==C).
  - Low while any channel has a pending difference.
- Reset mid-operation:
  - All pending counts are discarded and outputs forced to 0, even if raw inputs are 1.
  - After rst drops, a held-high raw input needs the full STABLE_CYCLES+2 edges again.
- Channels never interact; one channel's glitch does not affect another channel's count.
- No combinational path from any x_raw to any output.

Test Plan:
- Reset: hold rst 3 cycles with all raw=1 -> A=B=C=0, chg=0, all_stable=1. Release rst, keep raw=1 -> A/B/C rise on the 10th edge after release. chg=1 for exactly that cycle; all_stable=0 for edges 2..9 after release, then 1.
- Glitch reject (default params): a_raw high for 5 cycles, then low -> A stays 0, chg never asserts, all_stable returns to 1.
- Threshold boundary: a_raw held high for exactly 8 cycles then low -> A rises after 10 edges. A falls 8 cycles after s2 returns low; two chg pulses total.
- Simultaneous channels: a_raw and c_raw rise on the same edge, b_raw stays 0 -> A and C rise on the same edge, single 1-cycle chg pulse, B=0.
- Reset mid-count: b_raw high, assert rst at edge 6 of counting, release -> B=0 throughout. B rises 10 edges after rst deasserts.
- STABLE_CYCLES=1, CNT_W=1: c_raw toggles every 3 cycles -> C follows each toggle 2 edges later, with one chg pulse per toggle.
